// File: rtl/pipe_flow_ctrl_if.sv
// pipe_flow_ctrl_if
//   Handshake bundle between the hazard unit / datapath (master) and the
//   pipeline flow controller (slave).
//   master drives : npipe_stall, *_FLUSH, pc_WEN, dpif_ihit, dpif_dhit,
//                   id_Halt, id_DataRead, id_DataWrite, ex_branch_taken, ex_jump
//   slave drives  : *_WEN, stage_valid, flushes, npc_change, exmem_datarequest,
//                   idex_Halt, dpif_halt, retired_count, stall_count
//   Stage-indexed vectors use [0:3] = {ifid, idex, exmem, memwb}.
interface pipe_flow_ctrl_if;
  typedef struct packed {
    logic ifid;
    logic idex;
    logic exmem;
    logic memwb;
  } pipe_stall_t;

  pipe_stall_t npipe_stall;
  logic        ifid_FLUSH;
  logic        idex_FLUSH;
  logic        exmem_FLUSH;
  logic        memwb_FLUSH;
  logic        pc_WEN;
  logic        dpif_ihit;
  logic        dpif_dhit;
  logic        id_Halt;
  logic        id_DataRead;
  logic        id_DataWrite;
  logic        ex_branch_taken;
  logic        ex_jump;

  logic        ifid_WEN;
  logic        idex_WEN;
  logic        exmem_WEN;
  logic        memwb_WEN;
  logic [0:3]  stage_valid;
  logic [0:3]  flushes;
  logic        npc_change;
  logic        exmem_datarequest;
  logic        idex_Halt;
  logic        dpif_halt;
  logic [31:0] retired_count;
  logic [31:0] stall_count;

  modport master (
    output npipe_stall, ifid_FLUSH, idex_FLUSH, exmem_FLUSH, memwb_FLUSH,
    output pc_WEN, dpif_ihit, dpif_dhit, id_Halt, id_DataRead, id_DataWrite,
    output ex_branch_taken, ex_jump,
    input  ifid_WEN, idex_WEN, exmem_WEN, memwb_WEN, stage_valid, flushes,
    input  npc_change, exmem_datarequest, idex_Halt, dpif_halt,
    input  retired_count, stall_count
  );

  modport slave (
    input  npipe_stall, ifid_FLUSH, idex_FLUSH, exmem_FLUSH, memwb_FLUSH,
    input  pc_WEN, dpif_ihit, dpif_dhit, id_Halt, id_DataRead, id_DataWrite,
    input  ex_branch_taken, ex_jump,
    output ifid_WEN, idex_WEN, exmem_WEN, memwb_WEN, stage_valid, flushes,
    output npc_change, exmem_datarequest, idex_Halt, dpif_halt,
    output retired_count, stall_count
  );
endinterface

// File: rtl/pipe_flow_ctrl.sv
// pipe_flow_ctrl
//   Applies hazard-unit stall/flush commands to the four pipeline latches,
//   tracks {valid, halt, rd, wr} per latch, and from that state produces the
//   redirect/flush requests, the data-memory request, the halt drain FSM and
//   the retired / stall-cycle performance counters.
//   Ports: CLK (rising edge), RST (async, active-high), bus (slave modport of
//   pipe_flow_ctrl_if carrying every handshake signal).
module pipe_flow_ctrl (
  input  logic             CLK,
  input  logic             RST,
  pipe_flow_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {S_RUN = 2'd0, S_DRAIN = 2'd1, S_HALTED = 2'd2} state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    if (en && (v != 32'hFFFF_FFFF)) return v + 32'd1;
    return v;
  endfunction

  state_t      state_q, state_d;
  logic [0:3]  valid_q, valid_d;
  logic [0:3]  halt_q, halt_d;
  logic [0:3]  rd_q, rd_d;
  logic [0:3]  wr_q, wr_d;
  logic        done_q, done_d;
  logic [31:0] retired_count_q, retired_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  logic        run_en, fetch_en, halted;
  logic [0:3]  stall_v, flush_v, wen_v;
  logic [0:3]  up_valid, up_halt, up_rd, up_wr;
  logic        redirect, dreq, halt_enter, halt_flushed, retire_inc;

  // IF/ID decode bits are supplied live by id_*, and nothing consumes the
  // MEM/WB memory-op bits; they are kept so every stage carries the same record.
  logic        unused_bits;
  assign unused_bits = ^{halt_q[0], rd_q[0], wr_q[0], rd_q[3], wr_q[3]};

  // FSM output process
  always_comb begin
    run_en   = (state_q != S_HALTED);
    fetch_en = (state_q == S_RUN);
    halted   = (state_q == S_HALTED);
  end

  always_comb begin
    stall_v = bus.npipe_stall;
    flush_v = {bus.ifid_FLUSH, bus.idex_FLUSH, bus.exmem_FLUSH, bus.memwb_FLUSH};
    // A flush forces the latch open so the bubble is loaded even when stalled.
    wen_v   = {4{run_en}} & (~stall_v | flush_v);
  end

  always_comb begin
    up_valid = {fetch_en & bus.dpif_ihit & bus.pc_WEN, valid_q[0], valid_q[1], valid_q[2]};
    up_halt  = {1'b0, valid_q[0] & bus.id_Halt,      halt_q[1], halt_q[2]};
    up_rd    = {1'b0, valid_q[0] & bus.id_DataRead,  rd_q[1],   rd_q[2]};
    up_wr    = {1'b0, valid_q[0] & bus.id_DataWrite, wr_q[1],   wr_q[2]};
  end

  // A closed latch (stalled, or halted) keeps its record; an open one
  // either takes a bubble or the upstream record.
  always_comb begin
    valid_d = valid_q;
    halt_d  = halt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    for (int i = 0; i < 4; i++) begin
      if (wen_v[i]) begin
        if (flush_v[i]) begin
          valid_d[i] = 1'b0;
          halt_d[i]  = 1'b0;
          rd_d[i]    = 1'b0;
          wr_d[i]    = 1'b0;
        end else begin
          valid_d[i] = up_valid[i];
          halt_d[i]  = up_halt[i];
          rd_d[i]    = up_rd[i];
          wr_d[i]    = up_wr[i];
        end
      end
    end
  end

  always_comb begin
    redirect = valid_q[1] & (bus.ex_branch_taken | bus.ex_jump);
    dreq     = valid_q[2] & (rd_q[2] | wr_q[2]) & ~done_q;
  end

  // done remembers that MEM already got its hit, so a stalled access is not
  // reissued; it is forgotten once EX/MEM takes a new record.
  always_comb begin
    done_d = done_q;
    if (flush_v[2] || wen_v[2]) done_d = 1'b0;
    else if (bus.dpif_dhit && dreq) done_d = 1'b1;
  end

  always_comb begin
    halt_enter   = valid_q[0] & bus.id_Halt & wen_v[1] & ~flush_v[1];
    halt_flushed = |(flush_v[1:3] & halt_q[1:3]);
  end

  // FSM next-state process
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:    if (halt_enter) state_d = S_DRAIN;
      S_DRAIN: begin
        // A squashed halt (e.g. wrong-path) cancels the drain.
        if (halt_flushed)                  state_d = S_RUN;
        else if (valid_q[3] && halt_q[3])  state_d = S_HALTED;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_RUN;
    endcase
  end

  always_comb begin
    retire_inc      = valid_q[2] & wen_v[3] & ~flush_v[3] & ~stall_v[3];
    retired_count_d = sat_inc(retired_count_q, retire_inc);
    stall_count_d   = sat_inc(stall_count_q, run_en & (|stall_v));
  end

  // FSM state register and tracked state
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q         <= S_RUN;
      valid_q         <= '0;
      halt_q          <= '0;
      rd_q            <= '0;
      wr_q            <= '0;
      done_q          <= 1'b0;
      retired_count_q <= '0;
      stall_count_q   <= '0;
    end else begin
      state_q         <= state_d;
      valid_q         <= valid_d;
      halt_q          <= halt_d;
      rd_q            <= rd_d;
      wr_q            <= wr_d;
      done_q          <= done_d;
      retired_count_q <= retired_count_d;
      stall_count_q   <= stall_count_d;
    end
  end

  assign bus.ifid_WEN          = wen_v[0];
  assign bus.idex_WEN          = wen_v[1];
  assign bus.exmem_WEN         = wen_v[2];
  assign bus.memwb_WEN         = wen_v[3];
  assign bus.stage_valid       = valid_q;
  assign bus.flushes           = {redirect, redirect, 2'b00};
  assign bus.npc_change        = redirect;
  assign bus.exmem_datarequest = dreq;
  assign bus.idex_Halt         = valid_q[1] & halt_q[1];
  assign bus.dpif_halt         = halted;
  assign bus.retired_count     = retired_count_q;
  assign bus.stall_count       = stall_count_q;
endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// tb_pipe_flow_ctrl
//   Bench for pipe_flow_ctrl: a table of per-cycle vectors, hand-written
//   multi-cycle sequences (load with late hit, halt drain and its cancel,
//   counter saturation, async reset) and a randomized run, all compared every
//   cycle against a record-per-stage reference model.
module tb_pipe_flow_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_flow_ctrl_if hif ();
  pipe_flow_ctrl dut (.CLK(clk), .RST(rst), .bus(hif));

  typedef struct packed {
    logic [0:3] stall;
    logic [0:3] flush;
    logic ihit, pcwen, dhit, idh, idr, idw, br, jmp;
  } in_t;

  typedef struct {
    in_t         in;
    logic [0:3]  sv, wen, fl;
    logic        npc;
    logic [31:0] ret, sc;
  } vec_t;

  typedef struct packed { logic v, h, r, w; } rec_t;

  in_t   cur;
  vec_t  tbl [12];
  int    n_chk = 0;
  int    n_err = 0;

  // reference model state
  rec_t        m_stg [4];
  int          m_state;      // 0 run, 1 drain, 2 halted
  logic        m_done;
  logic [31:0] m_ret, m_stl;
  logic [0:3]  e_wen;
  logic        e_red, e_dreq, e_run;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    hif.npipe_stall     = cur.stall;
    hif.ifid_FLUSH      = cur.flush[0];
    hif.idex_FLUSH      = cur.flush[1];
    hif.exmem_FLUSH     = cur.flush[2];
    hif.memwb_FLUSH     = cur.flush[3];
    hif.pc_WEN          = cur.pcwen;
    hif.dpif_ihit       = cur.ihit;
    hif.dpif_dhit       = cur.dhit;
    hif.id_Halt         = cur.idh;
    hif.id_DataRead     = cur.idr;
    hif.id_DataWrite    = cur.idw;
    hif.ex_branch_taken = cur.br;
    hif.ex_jump         = cur.jmp;
  endtask

  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_stg[i] = '0;
    m_state = 0;
    m_done  = 1'b0;
    m_ret   = '0;
    m_stl   = '0;
  endtask

  task automatic m_comb();
    e_run = (m_state != 2);
    for (int i = 0; i < 4; i++) e_wen[i] = e_run && (!cur.stall[i] || cur.flush[i]);
    e_red  = m_stg[1].v && (cur.br || cur.jmp);
    e_dreq = m_stg[2].v && (m_stg[2].r || m_stg[2].w) && !m_done;
  endtask

  // Advance the model by one clock edge using the inputs held in cur.
  task automatic m_step();
    rec_t nxt [4];
    rec_t up;
    bit   halt_squashed;
    m_comb();
    for (int i = 3; i >= 0; i--) begin
      if (i == 0)      up = '{v: cur.ihit && cur.pcwen && m_state == 0, h: 0, r: 0, w: 0};
      else if (i == 1) up = '{v: m_stg[0].v, h: cur.idh && m_stg[0].v,
                              r: cur.idr && m_stg[0].v, w: cur.idw && m_stg[0].v};
      else             up = m_stg[i-1];
      if (m_state == 2)       nxt[i] = m_stg[i];
      else if (cur.flush[i])  nxt[i] = '0;
      else if (cur.stall[i])  nxt[i] = m_stg[i];
      else                    nxt[i] = up;
    end
    if (cur.flush[2] || e_wen[2]) m_done = 1'b0;
    else if (cur.dhit && e_dreq)  m_done = 1'b1;
    halt_squashed = 0;
    for (int i = 1; i < 4; i++) if (cur.flush[i] && m_stg[i].h) halt_squashed = 1;
    if (m_state == 0) begin
      if (m_stg[0].v && cur.idh && e_wen[1] && !cur.flush[1]) m_state = 1;
    end else if (m_state == 1) begin
      if (halt_squashed) m_state = 0;
      else if (m_stg[3].v && m_stg[3].h) m_state = 2;
    end
    if (m_stg[2].v && e_wen[3] && !cur.flush[3] && !cur.stall[3] && m_ret != 32'hFFFF_FFFF)
      m_ret = m_ret + 1;
    if (e_run && (cur.stall != 4'b0000) && m_stl != 32'hFFFF_FFFF)
      m_stl = m_stl + 1;
    for (int i = 0; i < 4; i++) m_stg[i] = nxt[i];
  endtask

  task automatic check_model();
    m_comb();
    chk("model_valid", hif.stage_valid, {m_stg[0].v, m_stg[1].v, m_stg[2].v, m_stg[3].v});
    chk("model_wen", {hif.ifid_WEN, hif.idex_WEN, hif.exmem_WEN, hif.memwb_WEN}, e_wen);
    chk("model_flushes", hif.flushes, {e_red, e_red, 2'b00});
    chk("model_npc", hif.npc_change, e_red);
    chk("model_dreq", hif.exmem_datarequest, e_dreq);
    chk("model_idex_halt", hif.idex_Halt, m_stg[1].v && m_stg[1].h);
    chk("model_dpif_halt", hif.dpif_halt, m_state == 2);
    chk("model_retired", hif.retired_count, m_ret);
    chk("model_stalls", hif.stall_count, m_stl);
  endtask

  task automatic cyc_pre();
    drive();
    #1;
    check_model();
  endtask

  task automatic cyc_post();
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic tick();
    cyc_pre();
    cyc_post();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cur = '0;
    drive();
    m_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic async_reset_chk(input string tag);
    #2 rst = 1'b1;
    #1;
    m_reset();
    chk({tag, "_valid"}, hif.stage_valid, 4'b0000);
    chk({tag, "_dpif_halt"}, hif.dpif_halt, 1'b0);
    chk({tag, "_retired"}, hif.retired_count, 32'd0);
    chk({tag, "_stalls"}, hif.stall_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic vec_t mk(input logic [0:3] st, input logic [0:3] fl_in, input logic ihit,
                              input logic br, input logic [0:3] sv, input logic [0:3] wen,
                              input logic [0:3] fl, input logic npc, input int ret, input int sc);
    vec_t v;
    v.in       = '0;
    v.in.stall = st;
    v.in.flush = fl_in;
    v.in.ihit  = ihit;
    v.in.pcwen = 1'b1;
    v.in.br    = br;
    v.sv  = sv;  v.wen = wen;  v.fl = fl;  v.npc = npc;
    v.ret = 32'(ret);  v.sc = 32'(sc);
    return v;
  endfunction

  initial begin
    // expected values are what the outputs show during that row's cycle
    tbl[0]  = mk(4'b0000, 4'b0000, 1, 0, 4'b0000, 4'b1111, 4'b0000, 0, 0, 0);
    tbl[1]  = mk(4'b0000, 4'b0000, 1, 0, 4'b1000, 4'b1111, 4'b0000, 0, 0, 0);
    tbl[2]  = mk(4'b0000, 4'b0000, 1, 0, 4'b1100, 4'b1111, 4'b0000, 0, 0, 0);
    tbl[3]  = mk(4'b0000, 4'b0000, 1, 0, 4'b1110, 4'b1111, 4'b0000, 0, 0, 0);
    tbl[4]  = mk(4'b0000, 4'b0000, 0, 0, 4'b1111, 4'b1111, 4'b0000, 0, 1, 0);
    tbl[5]  = mk(4'b0100, 4'b0100, 0, 0, 4'b0111, 4'b1111, 4'b0000, 0, 2, 0);
    tbl[6]  = mk(4'b0000, 4'b0000, 0, 0, 4'b0011, 4'b1111, 4'b0000, 0, 3, 1);
    tbl[7]  = mk(4'b0000, 4'b0000, 1, 0, 4'b0001, 4'b1111, 4'b0000, 0, 4, 1);
    tbl[8]  = mk(4'b0000, 4'b0000, 1, 0, 4'b1000, 4'b1111, 4'b0000, 0, 4, 1);
    tbl[9]  = mk(4'b0000, 4'b1100, 1, 1, 4'b1100, 4'b1111, 4'b1100, 1, 4, 1);
    tbl[10] = mk(4'b1000, 4'b0000, 0, 0, 4'b0010, 4'b0111, 4'b0000, 0, 4, 1);
    tbl[11] = mk(4'b0000, 4'b0000, 0, 0, 4'b0001, 4'b1111, 4'b0000, 0, 5, 2);

    do_reset();
    drive();
    #1;
    chk("rst_valid", hif.stage_valid, 4'b0000);
    chk("rst_flushes", hif.flushes, 4'b0000);
    chk("rst_npc", hif.npc_change, 1'b0);
    chk("rst_dreq", hif.exmem_datarequest, 1'b0);
    chk("rst_idex_halt", hif.idex_Halt, 1'b0);
    chk("rst_dpif_halt", hif.dpif_halt, 1'b0);
    chk("rst_wen", {hif.ifid_WEN, hif.idex_WEN, hif.exmem_WEN, hif.memwb_WEN}, 4'b1111);
    chk("rst_counters", hif.retired_count | hif.stall_count, 32'd0);

    // table-driven: straight-line flow, stall vs flush, taken branch
    for (int r = 0; r < 12; r++) begin
      cur = tbl[r].in;
      cyc_pre();
      chk($sformatf("tbl%0d_valid", r), hif.stage_valid, tbl[r].sv);
      chk($sformatf("tbl%0d_wen", r), {hif.ifid_WEN, hif.idex_WEN, hif.exmem_WEN, hif.memwb_WEN}, tbl[r].wen);
      chk($sformatf("tbl%0d_flushes", r), hif.flushes, tbl[r].fl);
      chk($sformatf("tbl%0d_npc", r), hif.npc_change, tbl[r].npc);
      chk($sformatf("tbl%0d_retired", r), hif.retired_count, tbl[r].ret);
      chk($sformatf("tbl%0d_stalls", r), hif.stall_count, tbl[r].sc);
      cyc_post();
    end

    // load held in EX/MEM, hit on the third request cycle
    do_reset();
    cur.pcwen = 1; cur.ihit = 1; tick();
    cur.ihit = 0; cur.idr = 1; tick();
    cur.idr = 0; tick();
    cur.stall = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      cur.dhit = (k == 2);
      drive(); #1;
      chk($sformatf("load_req_c%0d", k), hif.exmem_datarequest, 1'b1);
      cyc_post();
    end
    cur.dhit = 0;
    drive(); #1;
    chk("load_req_after_hit", hif.exmem_datarequest, 1'b0);
    cyc_post();
    cur.stall = 4'b0000;
    drive(); #1;
    chk("load_req_release", hif.exmem_datarequest, 1'b0);
    cyc_post();
    drive(); #1;
    chk("load_req_advanced", hif.exmem_datarequest, 1'b0);

    // halt drain to HALTED, then async reset out of HALTED
    do_reset();
    cur.pcwen = 1; cur.ihit = 1; tick();
    cur.idh = 1; tick();
    cur.idh = 0;
    drive(); #1;
    chk("halt_in_idex", hif.idex_Halt, 1'b1);
    tick();
    chk("halt_no_fetch", hif.stage_valid[0], 1'b0);
    tick();
    chk("halt_not_yet", hif.dpif_halt, 1'b0);
    tick();
    chk("halt_reached", hif.dpif_halt, 1'b1);
    chk("halt_wen", {hif.ifid_WEN, hif.idex_WEN, hif.exmem_WEN, hif.memwb_WEN}, 4'b0000);
    chk("halt_retired", hif.retired_count, 32'd2);
    tick();
    chk("halt_sticky", hif.dpif_halt, 1'b1);
    async_reset_chk("rst_halted");

    // halt squashed in EX/MEM cancels the drain
    do_reset();
    cur.pcwen = 1; cur.ihit = 1; tick();
    cur.idh = 1; tick();
    cur.idh = 0; cur.ihit = 0; tick();
    cur.flush = 4'b0010; tick();
    cur.flush = 4'b0000; cur.ihit = 1; tick();
    chk("cancel_fetch_resumes", hif.stage_valid[0], 1'b1);
    cur.ihit = 0;
    for (int k = 0; k < 5; k++) tick();
    chk("cancel_no_halt", hif.dpif_halt, 1'b0);

    // counter saturation from preloaded values, then async reset
    do_reset();
    cur.pcwen = 1; cur.ihit = 1; tick();
    drive();
    force dut.stall_count_q = 32'hFFFF_FFFD;
    force dut.retired_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_count_q;
    release dut.retired_count_q;
    m_stl = 32'hFFFF_FFFD;
    m_ret = 32'hFFFF_FFFE;
    cur.stall = 4'b1000;
    for (int k = 0; k < 7; k++) tick();
    chk("sat_stalls", hif.stall_count, 32'hFFFF_FFFF);
    chk("sat_retired", hif.retired_count, 32'hFFFF_FFFF);
    async_reset_chk("rst_counters");

    // randomized run against the reference model
    for (int n = 0; n < 1500; n++) begin
      if (n % 150 == 0) do_reset();
      for (int i = 0; i < 4; i++) begin
        cur.stall[i] = ($urandom_range(0, 3) == 0);
        cur.flush[i] = ($urandom_range(0, 9) == 0);
      end
      cur.ihit  = ($urandom_range(0, 3) != 0);
      cur.pcwen = ($urandom_range(0, 4) != 0);
      cur.dhit  = $urandom_range(0, 1) == 1;
      cur.idh   = ($urandom_range(0, 15) == 0);
      cur.idr   = ($urandom_range(0, 3) == 0);
      cur.idw   = ($urandom_range(0, 3) == 0);
      cur.br    = ($urandom_range(0, 4) == 0);
      cur.jmp   = ($urandom_range(0, 9) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
